// File: rtl/spi_bridge_pkg.sv
// Shared FSM encodings, SPI mode constants and synchroniser depth for the SPI bridge.
package spi_bridge_pkg;

    typedef logic [1:0] spi_state_t;

    localparam spi_state_t ST_IDLE         = 2'd0;
    localparam spi_state_t ST_ACTIVE       = 2'd1;
    localparam spi_state_t ST_WAIT_CS_HIGH = 2'd2;

    // {CPOL, CPHA}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    localparam int SPI_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_bridge_param_sync_edge.sv
// Two-flop synchroniser with a one-flop delay for rise/fall detection in the clk domain.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);
    import spi_bridge_pkg::*;

    logic [SPI_SYNC_STAGES-1:0] sync_q, sync_d;
    logic                       dly_q, dly_d;

    always_comb begin
        sync_d = {sync_q[SPI_SYNC_STAGES-2:0], d};
        dly_d  = sync_q[SPI_SYNC_STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= {SPI_SYNC_STAGES{RST_VAL}};
            dly_q  <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign lvl  = sync_q[SPI_SYNC_STAGES-1];
    assign rise = lvl & ~dly_q;
    assign fall = ~lvl & dly_q;

endmodule

// File: rtl/spi_bridge_param.sv
// Parametrised SPI slave bridge (any CPOL/CPHA, DATA_W-bit words) fully in the clk domain.
// Define SPI_BRIDGE_LSB_FIRST_EN for LSB-first transfers; MSB-first otherwise.
module spi_bridge_param #(
    parameter int DATA_W = 8,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              miso,
    output logic              mosi,
    output logic              byte_sync,
    output logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] data_out,
    output logic              tx_load,
    output logic              frame_err,
    output logic              busy
);
    import spi_bridge_pkg::*;

    localparam int         CNT_W       = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [1:0] MODE        = {CPOL[0], CPHA[0]};
    localparam logic       CPOL_B      = (MODE == SPI_MODE2) || (MODE == SPI_MODE3);
    localparam logic       SAMPLE_LEAD = (MODE == SPI_MODE0) || (MODE == SPI_MODE2);

    function automatic logic tx_bit(input logic [DATA_W-1:0] w);
`ifdef SPI_BRIDGE_LSB_FIRST_EN
        return w[0];
`else
        return w[DATA_W-1];
`endif
    endfunction

    function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
`ifdef SPI_BRIDGE_LSB_FIRST_EN
        return {1'b0, w[DATA_W-1:1]};
`else
        return {w[DATA_W-2:0], 1'b0};
`endif
    endfunction

    function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
`ifdef SPI_BRIDGE_LSB_FIRST_EN
        return {b, w[DATA_W-1:1]};
`else
        return {w[DATA_W-2:0], b};
`endif
    endfunction

    logic sclk_lvl, sclk_rise, sclk_fall;
    logic cs_lvl, cs_rise, cs_fall;

    // cs_n resets to "selected" so a frame already running at reset release is never joined.
    spi_sync_edge #(.RST_VAL(CPOL_B)) u_sclk_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (sclk),
        .lvl  (sclk_lvl),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (cs_n),
        .lvl  (cs_lvl),
        .rise (cs_rise),
        .fall (cs_fall)
    );

    logic [SPI_SYNC_STAGES-1:0] miso_sync_q, miso_sync_d;
    logic                       miso_s;
    logic                       sclk_edge, lead_edge, trail_edge, sample_edge, shift_edge;

    assign miso_s      = miso_sync_q[SPI_SYNC_STAGES-1];
    assign sclk_edge   = sclk_rise | sclk_fall;
    assign lead_edge   = sclk_edge & (sclk_lvl != CPOL_B);
    assign trail_edge  = sclk_edge & (sclk_lvl == CPOL_B);
    assign sample_edge = SAMPLE_LEAD ? lead_edge : trail_edge;
    assign shift_edge  = SAMPLE_LEAD ? trail_edge : lead_edge;

    spi_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_W-1:0] rx_sr_q, rx_sr_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [DATA_W-1:0] rx_next;
    logic              mosi_q, mosi_d;
    logic              byte_sync_q, byte_sync_d;
    logic              tx_load_q, tx_load_d;
    logic              frame_err_q, frame_err_d;
    logic              start_q, start_d;
    logic              last_bit;

    assign rx_next  = rx_shift(rx_sr_q, miso_s);
    assign last_bit = (cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        miso_sync_d = {miso_sync_q[SPI_SYNC_STAGES-2:0], miso};
        state_d     = state_q;
        cnt_d       = cnt_q;
        tx_sr_d     = tx_sr_q;
        rx_sr_d     = rx_sr_q;
        data_in_d   = data_in_q;
        mosi_d      = mosi_q;
        byte_sync_d = 1'b0;
        tx_load_d   = 1'b0;
        frame_err_d = 1'b0;
        start_d     = 1'b0;

        case (state_q)
            ST_WAIT_CS_HIGH: begin
                mosi_d = 1'b0;
                if (cs_lvl) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                mosi_d = 1'b0;
                if (cs_fall) begin
                    state_d   = ST_ACTIVE;
                    tx_load_d = 1'b1;
                    start_d   = 1'b1;
                    cnt_d     = '0;
                end
            end
            ST_ACTIVE: begin
                // data_out is captured while tx_load is high; CPHA=0 must show bit 0 before any edge.
                if (tx_load_q) begin
                    tx_sr_d = data_out;
                    if (start_q && SAMPLE_LEAD) begin
                        mosi_d  = tx_bit(data_out);
                        tx_sr_d = tx_shift(data_out);
                    end
                end else if (shift_edge) begin
                    mosi_d  = tx_bit(tx_sr_q);
                    tx_sr_d = tx_shift(tx_sr_q);
                end

                if (sample_edge) begin
                    rx_sr_d = rx_next;
                    if (last_bit) begin
                        cnt_d       = '0;
                        data_in_d   = rx_next;
                        byte_sync_d = 1'b1;
                        tx_load_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end

                // A word finishing in the same cycle as deselect counts as complete.
                if (cs_rise) begin
                    state_d     = ST_IDLE;
                    mosi_d      = 1'b0;
                    frame_err_d = (cnt_d != '0);
                end
            end
            default: state_d = ST_WAIT_CS_HIGH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_CS_HIGH;
            cnt_q       <= '0;
            data_in_q   <= '0;
            mosi_q      <= 1'b0;
            byte_sync_q <= 1'b0;
            tx_load_q   <= 1'b0;
            frame_err_q <= 1'b0;
            start_q     <= 1'b0;
            miso_sync_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_in_q   <= data_in_d;
            mosi_q      <= mosi_d;
            byte_sync_q <= byte_sync_d;
            tx_load_q   <= tx_load_d;
            frame_err_q <= frame_err_d;
            start_q     <= start_d;
            miso_sync_q <= miso_sync_d;
        end
    end

    // Shift registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        tx_sr_q <= tx_sr_d;
        rx_sr_q <= rx_sr_d;
    end

    assign mosi      = mosi_q;
    assign byte_sync = byte_sync_q;
    assign data_in   = data_in_q;
    assign tx_load   = tx_load_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == ST_ACTIVE);

endmodule
